bram_fifo_ctrl: RTL and testbench
=================================

# bram_fifo_ctrl

Stream FIFO controller that sequences the 2048x8 dual-port block RAM (RAMB16_S9_S9) as a 2048-entry byte FIFO between two ready/valid interfaces. Port A is write-only and port B is read-only. The controller owns the pointers, occupancy and read prefetch, and hides the RAM's 1-cycle read latency behind a 2-entry output buffer. It sits between line-buffer producers and downstream consumers wherever a deep elastic byte buffer is needed.

## Interface
- DEPTH, 2048: total capacity in entries. Fixed by the RAM geometry; the only legal value.
- CLK  in  1  sole clock; also drives RAM CLKA and CLKB.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a byte.
- in_data  in  8  producer byte.
- in_ready  out  1  FIFO accepts a byte this cycle.
- out_valid  out  1  out_data is valid.
- out_data  out  8  head byte.
- out_ready  in  1  consumer takes the head this cycle.
- count  out  12  total entries held (RAM + pending read + output buffer), 0..2048.

## Operation
- Registered state:
  - wp, rp: 11-bit pointers; natural wrap 2047→0.
  - ram_cnt: 12-bit, entries in RAM not yet read.
  - rd_pending: 1-bit, RAM read issued last cycle.
  - ob: 2-entry output queue with ob_cnt 0..2.
- count = ram_cnt + rd_pending + ob_cnt. in_ready = (count < 2048). in_ready is registered-state only; it never depends on out_ready.
- push = in_valid && in_ready. Drives ENA = WEA = push, ADDRA = wp, DIA = in_data. wp increments on push.
- pop = out_valid && out_ready. out_valid = (ob_cnt != 0); out_data = ob head.
- rd_issue = (ram_cnt != 0) && (ob_cnt + rd_pending - pop < 2). Drives ENB = rd_issue, WEB = 0, ADDRB = rp. rp increments on rd_issue. rd_pending <= rd_issue.
- When rd_pending is set, DOB is appended to the ob tail this edge. A simultaneous pop removes the head first.
- ram_cnt next = ram_cnt + push - rd_issue.
- Write/read address collision cannot occur: rd_issue requires ram_cnt > 0, so rp != wp whenever push is possible. No same-address cross-port access is ever generated.
- DIPA/DIPB tie to 0. SSRA/SSRB tie to 0.
- Reset clears wp, rp, ram_cnt, rd_pending and ob_cnt. RAM contents are not cleared. Reset mid-operation discards all held data; the first post-reset push is read out correctly.

## Timing
- Reset values: in_ready = 1, out_valid = 0, count = 0. out_data is don't-care while out_valid = 0.
- First-word latency: push at edge N into an empty FIFO → out_valid high after edge N+2.
  - Edge N: RAM write.
  - Edge N+1: RAM read.
  - Edge N+2: ob load.
- Throughput: 1 push and 1 pop per cycle, sustained, with count constant.
- count updates one edge after the handshake. push and pop in the same cycle leave count unchanged.
- Full (count = 2048): in_ready = 0 even if pop is asserted that cycle. A freed slot is visible on the next cycle.
- Empty: out_valid = 0. out_ready is ignored.
- Pointer wrap is seamless; data order is preserved across the 2047→0 boundary.

## Structure
- Shared package holds:
  - FIFO_DEPTH = 2048, FIFO_AW = 11, FIFO_CW = 12.
  - The ob_cnt width constant.
- Sub-module: one RAMB16_S9_S9 instance, driven as above.
- Optional small sub-module: fifo_out_buf, the 2-entry output queue (push/pop/cnt).
- All remaining logic is flat in bram_fifo_ctrl.

## Test plan
- Reset then idle: in_ready = 1, out_valid = 0, count = 0 for 10 cycles. Assert reset mid-stream at count = 37 → count = 0 and out_valid = 0 after one edge.
- Single byte: push 0xA5 at edge N with out_ready = 1 → out_valid = 1, out_data = 0xA5 after edge N+2; popped next cycle; count returns to 0.
- Streaming: push 0x00..0xFF continuously with out_ready = 1. Outputs arrive in order, one per cycle after the 2-cycle fill, and count stays at 2–3 in steady state.
- Fill: push 2048 bytes with out_ready = 0 → count = 2048 and in_ready = 0. A 2049th in_valid is not accepted. Popping one byte → in_ready = 1 the next cycle.
- Wrap: with out_ready randomly toggled, push 5000 sequential bytes (value = index mod 256). Outputs match in order across pointer wrap; no loss or duplication.
- Backpressure: out_ready low for 3 cycles while out_valid = 1 → out_data stays stable; no RAM read is issued once ob_cnt = 2.

Source files
------------

// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared sizing constants for the BRAM-backed byte FIFO.
package bram_fifo_ctrl_pkg;

  localparam int FIFO_DEPTH = 2048;
  localparam int FIFO_AW    = 11;
  localparam int FIFO_CW    = 12;
  localparam int FIFO_DW    = 8;
  localparam int OB_CW      = 2;

endpackage

// File: rtl/bram_fifo_ctrl_ram.sv
// Behavioural 2048x8 dual-port block RAM with the RAMB16_S9_S9 pin subset
// used by the FIFO: port A write-only, port B registered read.
module bram_fifo_ctrl_ram
  import bram_fifo_ctrl_pkg::*;
(
  input  logic               CLKA,
  input  logic               ENA,
  input  logic               WEA,
  input  logic [FIFO_AW-1:0] ADDRA,
  input  logic [FIFO_DW-1:0] DIA,
  input  logic               CLKB,
  input  logic               ENB,
  input  logic               SSRB,
  input  logic [FIFO_AW-1:0] ADDRB,
  output logic [FIFO_DW-1:0] DOB
);

  logic [FIFO_DW-1:0] r_mem [FIFO_DEPTH];

  always_ff @(posedge CLKA) begin
    if (ENA && WEA) begin
      r_mem[ADDRA] <= DIA;
    end
  end

  always_ff @(posedge CLKB) begin
    if (ENB) begin
      if (SSRB) begin
        DOB <= '0;
      end else begin
        DOB <= r_mem[ADDRB];
      end
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// 2048-entry byte FIFO around a dual-port BRAM; a 2-entry output queue
// hides the RAM read latency so push and pop both run every cycle.
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [FIFO_DW-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [FIFO_DW-1:0] out_data,
  input  logic               out_ready,
  output logic [FIFO_CW-1:0] count
);

  logic [FIFO_AW-1:0] r_wp;
  logic [FIFO_AW-1:0] r_rp;
  logic [FIFO_CW-1:0] r_ram_cnt;
  logic               r_rd_pending;
  logic [OB_CW-1:0]   r_ob_cnt;
  logic [FIFO_DW-1:0] r_ob0;
  logic [FIFO_DW-1:0] r_ob1;

  logic               w_push;
  logic               w_pop;
  logic               w_rd_issue;
  logic [2:0]         w_ob_need;
  logic [OB_CW-1:0]   w_ob_left;
  logic [FIFO_DW-1:0] w_dob;
  logic [FIFO_CW-1:0] w_count;

  assign w_count = r_ram_cnt
                 + FIFO_CW'(r_rd_pending)
                 + FIFO_CW'(r_ob_cnt);

  assign count     = w_count;
  assign in_ready  = (w_count < FIFO_CW'(DEPTH));
  assign out_valid = (r_ob_cnt != '0);
  assign out_data  = r_ob0;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Only fetch when the queue can absorb the word after this cycle's pop.
  assign w_ob_need = 3'(r_ob_cnt)
                   + 3'(r_rd_pending)
                   - 3'(w_pop);
  assign w_rd_issue = (r_ram_cnt != '0)
                   && (w_ob_need < 3'd2);

  assign w_ob_left = r_ob_cnt - OB_CW'(w_pop);

  bram_fifo_ctrl_ram u_ram (
    .CLKA  (CLK),
    .ENA   (w_push),
    .WEA   (w_push),
    .ADDRA (r_wp),
    .DIA   (in_data),
    .CLKB  (CLK),
    .ENB   (w_rd_issue),
    .SSRB  (1'b0),
    .ADDRB (r_rp),
    .DOB   (w_dob)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_ram_cnt    <= '0;
      r_rd_pending <= 1'b0;
      r_ob_cnt     <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_rd_issue) begin
        r_rp <= r_rp + 1'b1;
      end
      r_ram_cnt <= r_ram_cnt
                 + FIFO_CW'(w_push)
                 - FIFO_CW'(w_rd_issue);
      r_rd_pending <= w_rd_issue;
      r_ob_cnt <= w_ob_left + OB_CW'(r_rd_pending);
    end
  end

  // Pop shifts the head out first; the landing RAM word then takes the
  // first free slot.
  always_ff @(posedge CLK) begin
    if (w_pop) begin
      r_ob0 <= r_ob1;
    end
    if (r_rd_pending) begin
      if (w_ob_left == '0) begin
        r_ob0 <= w_dob;
      end else begin
        r_ob1 <= w_dob;
      end
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl: accepted bytes are queued and
// matched against every popped byte.
module tb_bram_fifo_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [11:0] count;

  int n_cmp;
  int n_err;
  logic [7:0] sb_q [$];

  bram_fifo_ctrl dut (
    .CLK       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("pop_empty_sb", {24'd0, out_data}, 32'hffff_ffff);
        end else begin
          chk("out_data", {24'd0, out_data}, {24'd0, sb_q.pop_front()});
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      step();
      if (count == 12'd0 && !out_valid) done = 1'b1;
    end
    chk("drain_done", {31'd0, done}, 32'd1);
    chk("drain_sb_empty", sb_q.size(), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] held;
    bit acc;
    int idx;
    n_cmp = 0;
    n_err = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_count", {20'd0, count}, 32'd0);
    end

    // single byte, 2-edge first-word latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    step();
    in_valid = 1'b0;
    chk("single_cnt_n", {20'd0, count}, 32'd1);
    chk("single_ov_n", {31'd0, out_valid}, 32'd0);
    step();
    chk("single_ov_n1", {31'd0, out_valid}, 32'd0);
    step();
    chk("single_ov_n2", {31'd0, out_valid}, 32'd1);
    chk("single_data", {24'd0, out_data}, 32'hA5);
    step();
    chk("single_ov_after", {31'd0, out_valid}, 32'd0);
    chk("single_cnt_after", {20'd0, count}, 32'd0);

    // streaming
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      if (i >= 3) begin
        chk("stream_cnt_ge2", {31'd0, count >= 12'd2}, 32'd1);
        chk("stream_cnt_le3", {31'd0, count <= 12'd3}, 32'd1);
      end
    end
    drain();

    // fill to full
    out_ready = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      if (!in_ready) chk("fill_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = 8'(i * 7);
      step();
    end
    chk("full_count", {20'd0, count}, 32'd2048);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_data = 8'hEE;
    step();
    chk("full_reject_cnt", {20'd0, count}, 32'd2048);
    in_valid = 1'b0;

    // backpressure: head held, no RAM fetch with a full output queue
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_stable", {24'd0, out_data}, {24'd0, held});
      chk("bp_no_read", {31'd0, dut.w_rd_issue}, 32'd0);
    end

    // pop while full: in_ready stays low that cycle
    out_ready = 1'b1;
    chk("full_pop_ready", {31'd0, in_ready}, 32'd0);
    step();
    out_ready = 1'b0;
    chk("freed_ready", {31'd0, in_ready}, 32'd1);
    chk("freed_count", {20'd0, count}, 32'd2047);
    drain();

    // long run across pointer wrap with random backpressure
    idx = 0;
    for (int c = 0; c < 40000 && idx < 5000; c++) begin
      in_valid  = 1'b1;
      in_data   = 8'(idx);
      out_ready = 1'($urandom_range(0, 1));
      acc = in_ready;
      step();
      if (acc) idx++;
    end
    chk("wrap_all_pushed", idx, 32'd5000);
    drain();

    // reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 37; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 100);
      step();
    end
    in_valid = 1'b0;
    chk("pre_reset_cnt", {20'd0, count}, 32'd37);
    reset = 1'b1;
    step();
    chk("rst_count", {20'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    step();
    in_valid = 1'b1;
    in_data  = 8'h3C;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("post_rst_ov", {31'd0, out_valid}, 32'd1);
    chk("post_rst_data", {24'd0, out_data}, 32'h3C);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
